// File: rtl/flash_spi_arbiter_pkg.sv
// Shared encodings for the flash SPI arbiter. The top-level LED/status logic also uses them.
//   STATE_*  : 2-bit arbiter state codes (IDLE/EMU/USB/GAP)
//   OWNER_*  : 2-bit bus owner codes (NONE/EMU/USB)
package flash_spi_arbiter_pkg;

   localparam logic [1:0] STATE_IDLE = 2'd0;
   localparam logic [1:0] STATE_EMU  = 2'd1;
   localparam logic [1:0] STATE_USB  = 2'd2;
   localparam logic [1:0] STATE_GAP  = 2'd3;

   localparam logic [1:0] OWNER_NONE = 2'd0;
   localparam logic [1:0] OWNER_EMU  = 2'd1;
   localparam logic [1:0] OWNER_USB  = 2'd2;

   typedef enum logic [1:0] {
      StIdle = STATE_IDLE,
      StEmu  = STATE_EMU,
      StUsb  = STATE_USB,
      StGap  = STATE_GAP
   } arb_state_e;

   typedef enum logic [1:0] {
      OwnNone = OWNER_NONE,
      OwnEmu  = OWNER_EMU,
      OwnUsb  = OWNER_USB
   } owner_e;

endpackage

// File: rtl/flash_spi_mux.sv
// Combinational pin mux from the registered bus owner to the flash pins.
// Ports:
//   owner                    : current bus owner (none/emu/usb)
//   emu_cs, emu_mosi, emu_clk: emulator SPI signals (cs active low)
//   usb_cs, usb_mosi, usb_clk: USB/MPSSE SPI signals (cs active low)
//   rom_cs_n, rom_mosi, rom_clk: flash pins; idle bus when no owner
module flash_spi_mux
   import flash_spi_arbiter_pkg::*;
(
   input  owner_e owner,
   input  logic   emu_cs,
   input  logic   emu_mosi,
   input  logic   emu_clk,
   input  logic   usb_cs,
   input  logic   usb_mosi,
   input  logic   usb_clk,
   output logic   rom_cs_n,
   output logic   rom_mosi,
   output logic   rom_clk
);

   always_comb begin
      rom_cs_n = 1'b1;
      rom_mosi = 1'b0;
      rom_clk  = 1'b0;
      case (owner)
         OwnEmu: begin
            rom_cs_n = emu_cs;
            rom_mosi = emu_mosi;
            rom_clk  = emu_clk;
         end
         OwnUsb: begin
            rom_cs_n = usb_cs;
            rom_mosi = usb_mosi;
            rom_clk  = usb_clk;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/flash_spi_arbiter.sv
// Arbiter sharing the W25Q32 SPI flash between the emulator page loader (fixed priority)
// and the USB/MPSSE image uploader. An owner keeps the bus until it drops its request with
// its chip-select already high; only a USB disable (nUSBEN=1) cuts a transfer short.
// Every release is followed by GAP_CYCLES of idle bus before the next grant.
// Ports:
//   MCLK, RST                       : clock, synchronous active-high reset
//   nUSBEN                          : 0 = USB may request; 1 = ignore/abort USB
//   nEMUREQ/nEMUGNT, EMUCS/MOSI/CLK : emulator request, grant and SPI signals
//   nUSBREQ/nUSBGNT, USBCS/MOSI/CLK : USB request, grant and SPI signals
//   EMUMISO, USBMISO                : ROMMISO fanned out to both requesters
//   nROMCS, ROMMOSI, ROMCLK, ROMMISO: flash pins
//   nEMUSTALL                       : sticky emulator starvation flag, active low
module flash_spi_arbiter
   import flash_spi_arbiter_pkg::*;
#(
   parameter int unsigned GAP_CYCLES = 4,
   parameter int unsigned WAIT_LIMIT = 4096,
   parameter int unsigned WAITW      = 13
) (
   input  logic MCLK,
   input  logic RST,
   input  logic nUSBEN,
   input  logic nEMUREQ,
   output logic nEMUGNT,
   input  logic EMUCS,
   input  logic EMUMOSI,
   input  logic EMUCLK,
   input  logic nUSBREQ,
   output logic nUSBGNT,
   input  logic USBCS,
   input  logic USBMOSI,
   input  logic USBCLK,
   output logic EMUMISO,
   output logic USBMISO,
   output logic nROMCS,
   output logic ROMMOSI,
   output logic ROMCLK,
   input  logic ROMMISO,
   output logic nEMUSTALL
);

   localparam int unsigned GAPW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GAPW-1:0]  GapLast   = GAPW'(GAP_CYCLES - 1);
   localparam logic [WAITW-1:0] WaitLimit = WAITW'(WAIT_LIMIT);

   arb_state_e       state_q, state_d;
   owner_e           owner_q, owner_d;
   logic             emu_gnt_n_q, emu_gnt_n_d;
   logic             usb_gnt_n_q, usb_gnt_n_d;
   logic [GAPW-1:0]  gap_cnt_q, gap_cnt_d;
   logic [WAITW-1:0] wait_cnt_q, wait_cnt_d;
   logic             stall_n_q, stall_n_d;

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      emu_gnt_n_d = emu_gnt_n_q;
      usb_gnt_n_d = usb_gnt_n_q;
      gap_cnt_d   = gap_cnt_q;
      wait_cnt_d  = wait_cnt_q;
      stall_n_d   = stall_n_q;

      // Emulator waiting on a bus it cannot get right now.
      if ((state_q == StUsb || state_q == StGap) && !nEMUREQ && wait_cnt_q != WaitLimit) begin
         wait_cnt_d = wait_cnt_q + WAITW'(1);
      end
      if (wait_cnt_d == WaitLimit) begin
         stall_n_d = 1'b0;
      end

      case (state_q)
         StIdle: begin
            if (!nEMUREQ) begin
               state_d     = StEmu;
               owner_d     = OwnEmu;
               emu_gnt_n_d = 1'b0;
               wait_cnt_d  = '0;
               stall_n_d   = 1'b1;
            end else if (!nUSBREQ && !nUSBEN) begin
               state_d     = StUsb;
               owner_d     = OwnUsb;
               usb_gnt_n_d = 1'b0;
            end
         end
         StEmu: begin
            if (nEMUREQ && EMUCS) begin
               state_d     = StGap;
               owner_d     = OwnNone;
               emu_gnt_n_d = 1'b1;
               gap_cnt_d   = '0;
            end
         end
         StUsb: begin
            // A USB disable aborts even with USBCS low.
            if (nUSBEN || (nUSBREQ && USBCS)) begin
               state_d     = StGap;
               owner_d     = OwnNone;
               usb_gnt_n_d = 1'b1;
               gap_cnt_d   = '0;
            end
         end
         StGap: begin
            if (gap_cnt_q == GapLast) begin
               state_d   = StIdle;
               gap_cnt_d = '0;
            end else begin
               gap_cnt_d = gap_cnt_q + GAPW'(1);
            end
         end
         default: begin
            state_d     = StIdle;
            owner_d     = OwnNone;
            emu_gnt_n_d = 1'b1;
            usb_gnt_n_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge MCLK) begin
      if (RST) begin
         state_q     <= StIdle;
         owner_q     <= OwnNone;
         emu_gnt_n_q <= 1'b1;
         usb_gnt_n_q <= 1'b1;
         gap_cnt_q   <= '0;
         wait_cnt_q  <= '0;
         stall_n_q   <= 1'b1;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         emu_gnt_n_q <= emu_gnt_n_d;
         usb_gnt_n_q <= usb_gnt_n_d;
         gap_cnt_q   <= gap_cnt_d;
         wait_cnt_q  <= wait_cnt_d;
         stall_n_q   <= stall_n_d;
      end
   end

   assign nEMUGNT   = emu_gnt_n_q;
   assign nUSBGNT   = usb_gnt_n_q;
   assign nEMUSTALL = stall_n_q;
   assign EMUMISO   = ROMMISO;
   assign USBMISO   = ROMMISO;

   flash_spi_mux u_mux (
      .owner    (owner_q),
      .emu_cs   (EMUCS),
      .emu_mosi (EMUMOSI),
      .emu_clk  (EMUCLK),
      .usb_cs   (USBCS),
      .usb_mosi (USBMOSI),
      .usb_clk  (USBCLK),
      .rom_cs_n (nROMCS),
      .rom_mosi (ROMMOSI),
      .rom_clk  (ROMCLK)
   );

endmodule

// File: tb/tb_flash_spi_arbiter.sv
module tb_flash_spi_arbiter;

   localparam int unsigned GAP_CYCLES = 4;
   localparam int unsigned WAIT_LIMIT = 4096;
   localparam int unsigned WAITW      = 13;

   logic MCLK    = 1'b0;
   logic RST     = 1'b1;
   logic nUSBEN  = 1'b0;
   logic nEMUREQ = 1'b1;
   logic EMUCS   = 1'b1;
   logic EMUMOSI = 1'b0;
   logic EMUCLK  = 1'b0;
   logic nUSBREQ = 1'b1;
   logic USBCS   = 1'b1;
   logic USBMOSI = 1'b0;
   logic USBCLK  = 1'b0;
   logic ROMMISO = 1'b0;
   logic nEMUGNT, nUSBGNT, EMUMISO, USBMISO, nROMCS, ROMMOSI, ROMCLK, nEMUSTALL;

   flash_spi_arbiter #(
      .GAP_CYCLES (GAP_CYCLES),
      .WAIT_LIMIT (WAIT_LIMIT),
      .WAITW      (WAITW)
   ) dut (
      .MCLK      (MCLK),
      .RST       (RST),
      .nUSBEN    (nUSBEN),
      .nEMUREQ   (nEMUREQ),
      .nEMUGNT   (nEMUGNT),
      .EMUCS     (EMUCS),
      .EMUMOSI   (EMUMOSI),
      .EMUCLK    (EMUCLK),
      .nUSBREQ   (nUSBREQ),
      .nUSBGNT   (nUSBGNT),
      .USBCS     (USBCS),
      .USBMOSI   (USBMOSI),
      .USBCLK    (USBCLK),
      .EMUMISO   (EMUMISO),
      .USBMISO   (USBMISO),
      .nROMCS    (nROMCS),
      .ROMMOSI   (ROMMOSI),
      .ROMCLK    (ROMCLK),
      .ROMMISO   (ROMMISO),
      .nEMUSTALL (nEMUSTALL)
   );

   always #5 MCLK = ~MCLK;

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   // Reference model: who holds the bus, how much enforced idle is left, how long the
   // emulator has been kept waiting.
   int holder    = 0;  // 0 nobody, 1 emulator, 2 USB
   int gap_left  = 0;
   int emu_wait  = 0;
   bit starved   = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   function automatic void model_edge();
      if (RST) begin
         holder   = 0;
         gap_left = 0;
         emu_wait = 0;
         starved  = 1'b0;
         return;
      end
      if ((holder == 2 || gap_left > 0) && !nEMUREQ) begin
         if (emu_wait < int'(WAIT_LIMIT)) emu_wait++;
         if (emu_wait == int'(WAIT_LIMIT)) starved = 1'b1;
      end
      if (gap_left > 0) begin
         gap_left--;
      end else if (holder == 1) begin
         if (nEMUREQ && EMUCS) begin
            holder   = 0;
            gap_left = GAP_CYCLES;
         end
      end else if (holder == 2) begin
         if (nUSBEN || (nUSBREQ && USBCS)) begin
            holder   = 0;
            gap_left = GAP_CYCLES;
         end
      end else if (!nEMUREQ) begin
         holder   = 1;
         emu_wait = 0;
         starved  = 1'b0;
      end else if (!nUSBREQ && !nUSBEN) begin
         holder = 2;
      end
   endfunction

   task automatic check_outputs();
      logic [2:0] exp_pins;
      if (holder == 1)      exp_pins = {EMUCS, EMUMOSI, EMUCLK};
      else if (holder == 2) exp_pins = {USBCS, USBMOSI, USBCLK};
      else                  exp_pins = 3'b100;
      check_eq("grants", 32'({nEMUGNT, nUSBGNT}), 32'({holder != 1, holder != 2}));
      check_eq("pins", 32'({nROMCS, ROMMOSI, ROMCLK}), 32'(exp_pins));
      check_eq("miso", 32'({EMUMISO, USBMISO}), 32'({ROMMISO, ROMMISO}));
      check_eq("stall", 32'(nEMUSTALL), 32'(!starved));
   endtask

   // One MCLK period: wiggle data pins, check at the falling edge, step the model at the
   // rising edge, then leave 1 ns before the caller changes inputs.
   task automatic cycle();
      EMUMOSI = 1'($urandom);
      EMUCLK  = 1'($urandom);
      USBMOSI = 1'($urandom);
      USBCLK  = 1'($urandom);
      ROMMISO = 1'($urandom);
      @(negedge MCLK);
      if (chk_en) check_outputs();
      @(posedge MCLK);
      model_edge();
      #1;
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic wait_usb_grant(input string tag);
      int n = 0;
      while (nUSBGNT && n < 50) begin
         cycle();
         n++;
      end
      check_eq(tag, 32'(nUSBGNT), 32'(0));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog at %0t: got timeout expected finish", $time);
      $fatal(1);
   end

   initial begin
      int n;
      @(posedge MCLK);
      model_edge();
      #1;
      chk_en = 1'b1;
      cycle();
      RST = 1'b0;

      // Emulator page load.
      cycles(9);
      nEMUREQ = 1'b0;
      cycle();
      check_eq("emu_grant_latency", 32'(nEMUGNT), 32'(0));
      EMUCS = 1'b0;
      cycles(30);
      EMUCS   = 1'b1;
      nEMUREQ = 1'b1;
      cycles(8);

      // Simultaneous requests: emulator first, USB after release + gap + arbitration edge.
      nEMUREQ = 1'b0;
      nUSBREQ = 1'b0;
      cycle();
      check_eq("emu_priority", 32'({nEMUGNT, nUSBGNT}), 32'(2'b01));
      EMUCS = 1'b0;
      cycles(10);
      EMUCS   = 1'b1;
      nEMUREQ = 1'b1;
      n = 0;
      while (n < 50) begin
         cycle();
         n++;
         if (!nUSBGNT) break;
      end
      check_eq("usb_after_gap", 32'(n), 32'(GAP_CYCLES + 2));

      // USB drops request mid-transfer: grant held until USBCS rises.
      USBCS = 1'b0;
      cycles(2);
      nUSBREQ = 1'b1;
      cycles(20);
      check_eq("usb_hold", 32'(nUSBGNT), 32'(0));
      USBCS = 1'b1;
      cycle();
      check_eq("usb_release", 32'(nUSBGNT), 32'(1));
      cycles(6);

      // USB disabled mid-transfer.
      nUSBREQ = 1'b0;
      wait_usb_grant("usb_grant_abort");
      USBCS = 1'b0;
      cycles(3);
      nUSBEN = 1'b1;
      cycle();
      check_eq("usb_abort", 32'({nUSBGNT, nROMCS}), 32'(2'b11));
      cycles(2);
      nUSBEN  = 1'b0;
      nUSBREQ = 1'b1;
      USBCS   = 1'b1;
      cycles(8);

      // Emulator starved behind a long USB upload.
      nUSBREQ = 1'b0;
      wait_usb_grant("usb_grant_starve");
      USBCS   = 1'b0;
      nEMUREQ = 1'b0;
      n = 0;
      while (n < int'(WAIT_LIMIT) + 100) begin
         cycle();
         n++;
         if (!nEMUSTALL) break;
      end
      check_eq("stall_latency", 32'(n), 32'(WAIT_LIMIT));
      cycles(5000 - int'(WAIT_LIMIT));
      check_eq("stall_sticky", 32'(nEMUSTALL), 32'(0));
      nUSBREQ = 1'b1;
      USBCS   = 1'b1;
      n = 0;
      while (nEMUGNT && n < 50) begin
         cycle();
         n++;
      end
      check_eq("stall_clear", 32'({nEMUGNT, nEMUSTALL}), 32'(2'b01));
      nEMUREQ = 1'b1;
      cycles(8);

      // Reset during an emulator transfer, then a fresh grant.
      nEMUREQ = 1'b0;
      cycles(2);
      EMUCS = 1'b0;
      cycles(3);
      RST = 1'b1;
      cycle();
      check_eq("rst_mid_xfer", 32'({nEMUGNT, nROMCS, nEMUSTALL}), 32'(3'b111));
      RST = 1'b0;
      cycle();
      check_eq("regrant_after_rst", 32'(nEMUGNT), 32'(0));
      EMUCS   = 1'b1;
      nEMUREQ = 1'b1;
      cycles(8);

      // Random traffic against the model.
      for (int i = 0; i < 4000; i++) begin
         RST = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 15) == 0) nUSBEN = ~nUSBEN;
         if ($urandom_range(0, 7) == 0)  nEMUREQ = ~nEMUREQ;
         if ($urandom_range(0, 5) == 0)  nUSBREQ = ~nUSBREQ;
         if ($urandom_range(0, 2) == 0)  EMUCS = ~EMUCS;
         if ($urandom_range(0, 2) == 0)  USBCS = ~USBCS;
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
